// File: rtl/mgmt_storage_arbiter_pkg.sv
// Shared types for the mgmt/housekeeping SRAM arbiter: FSM encoding,
// requester ids and the bank-index width helper.
package mgmt_storage_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_MGMT = 1'b0,
    REQ_HK   = 1'b1
  } req_id_e;

  // A single bank still carries one (always-zero) bank bit in the address.
  function automatic int bank_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mgmt_storage_arbiter_if.sv
// Bus bundle between the mgmt Wishbone port, the housekeeping reader and
// the banked SRAM; "slave" is the arbiter side.
interface mgmt_storage_arbiter_if #(
  parameter int RAM_BLOCKS = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) ();
  import mgmt_storage_arbiter_pkg::*;

  localparam int SEL_W  = DATA_W / 8;
  localparam int BANK_W = bank_w(RAM_BLOCKS);

  logic                         wb_cyc_i, wb_stb_i, wb_we_i;
  logic [SEL_W-1:0]             wb_sel_i;
  logic [BANK_W+ADDR_W+1:0]     wb_adr_i;
  logic [DATA_W-1:0]            wb_dat_i;
  logic                         wb_ack_o;
  logic [DATA_W-1:0]            wb_dat_o;

  logic                         hk_req;
  logic [BANK_W+ADDR_W-1:0]     hk_addr;
  logic                         hk_valid;
  logic [DATA_W-1:0]            hk_rdata;

  logic [RAM_BLOCKS-1:0]        sram_ena, sram_wen;
  logic [RAM_BLOCKS*SEL_W-1:0]  sram_wen_mask;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;
  logic [RAM_BLOCKS*DATA_W-1:0] sram_rdata;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  hk_req, hk_addr, sram_rdata,
    output wb_ack_o, wb_dat_o, hk_valid, hk_rdata,
    output sram_ena, sram_wen, sram_wen_mask, sram_addr, sram_wdata
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output hk_req, hk_addr, sram_rdata,
    input  wb_ack_o, wb_dat_o, hk_valid, hk_rdata,
    input  sram_ena, sram_wen, sram_wen_mask, sram_addr, sram_wdata
  );

endinterface

// File: rtl/mgmt_storage_rr_arb.sv
// Two-requester round-robin arbiter; on contention the requester not
// served last wins. Last-served resets to HK so mgmt wins first.
module mgmt_storage_rr_arb
  import mgmt_storage_arbiter_pkg::*;
(
  input  logic    gclk,
  input  logic    grst_n,
  input  logic    req_mgmt,
  input  logic    req_hk,
  input  logic    take,
  output logic    gnt_vld,
  output req_id_e gnt_id
);

  req_id_e last;

  always_comb begin
    gnt_vld = req_mgmt | req_hk;
    if (req_mgmt && req_hk) gnt_id = (last == REQ_HK) ? REQ_MGMT : REQ_HK;
    else                    gnt_id = req_mgmt ? REQ_MGMT : REQ_HK;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                last <= REQ_HK;
    else if (take && gnt_vld)   last <= gnt_id;
  end

endmodule

// File: rtl/mgmt_storage_arbiter.sv
// Shares banked SRAM between the mgmt Wishbone port and a housekeeping
// reader: IDLE (grant+capture) -> ACCESS (registered SRAM strobe) -> RESP.
module mgmt_storage_arbiter
  import mgmt_storage_arbiter_pkg::*;
#(
  parameter int RAM_BLOCKS = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input logic                   core_clk,
  input logic                   core_rstn,
  mgmt_storage_arbiter_if.slave bus
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int BANK_W = bank_w(RAM_BLOCKS);

  arb_state_e                  state, state_nxt;
  logic                        gnt_vld, mgmt_req;
  req_id_e                     gnt_id, cur_id;
  logic [BANK_W-1:0]           req_bank, cur_bank;
  logic [ADDR_W-1:0]           req_word;
  logic                        req_we, cur_we, cyc_lost;
  logic [RAM_BLOCKS-1:0]       ena_nxt, wen_nxt;
  logic [RAM_BLOCKS*SEL_W-1:0] mask_nxt;
  logic [DATA_W-1:0]           rd_mux;
  logic [1:0]                  unused_adr;

  assign mgmt_req   = bus.wb_cyc_i & bus.wb_stb_i;
  assign unused_adr = bus.wb_adr_i[1:0];

  mgmt_storage_rr_arb u_arb (
    .gclk     (core_clk),
    .grst_n   (core_rstn),
    .req_mgmt (mgmt_req),
    .req_hk   (bus.hk_req),
    .take     (state == ST_IDLE),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_vld) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Out-of-range banks match no lane: no strobe, and the read mux falls
  // through to all-ones.
  always_comb begin
    req_bank = '0;
    req_word = '0;
    req_we   = 1'b0;
    if (gnt_id == REQ_MGMT) begin
      req_bank = bus.wb_adr_i[BANK_W+ADDR_W+1 -: BANK_W];
      req_word = bus.wb_adr_i[ADDR_W+1 -: ADDR_W];
      req_we   = bus.wb_we_i;
    end else begin
      req_bank = bus.hk_addr[BANK_W+ADDR_W-1 -: BANK_W];
      req_word = bus.hk_addr[ADDR_W-1:0];
    end
    ena_nxt  = '0;
    wen_nxt  = '0;
    mask_nxt = '0;
    for (int b = 0; b < RAM_BLOCKS; b++) begin
      if (int'(req_bank) == b) begin
        ena_nxt[b]                  = 1'b1;
        wen_nxt[b]                  = req_we;
        mask_nxt[b*SEL_W +: SEL_W]  = req_we ? bus.wb_sel_i : '0;
      end
    end
    rd_mux = '1;
    for (int b = 0; b < RAM_BLOCKS; b++)
      if (int'(cur_bank) == b) rd_mux = bus.sram_rdata[b*DATA_W +: DATA_W];
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cur_id            <= REQ_MGMT;
      cur_bank          <= '0;
      cur_we            <= 1'b0;
      cyc_lost          <= 1'b0;
      bus.sram_ena      <= '0;
      bus.sram_wen      <= '0;
      bus.sram_wen_mask <= '0;
      bus.sram_addr     <= '0;
      bus.sram_wdata    <= '0;
      bus.wb_ack_o      <= 1'b0;
      bus.wb_dat_o      <= '0;
      bus.hk_valid      <= 1'b0;
      bus.hk_rdata      <= '0;
    end else begin
      bus.sram_ena      <= '0;
      bus.sram_wen      <= '0;
      bus.sram_wen_mask <= '0;
      bus.sram_addr     <= '0;
      bus.sram_wdata    <= '0;
      bus.wb_ack_o      <= 1'b0;
      bus.hk_valid      <= 1'b0;
      if (state == ST_IDLE && gnt_vld) begin
        cur_id            <= gnt_id;
        cur_bank          <= req_bank;
        cur_we            <= req_we;
        bus.sram_ena      <= ena_nxt;
        bus.sram_wen      <= wen_nxt;
        bus.sram_wen_mask <= mask_nxt;
        bus.sram_addr     <= req_word;
        bus.sram_wdata    <= req_we ? bus.wb_dat_i : '0;
      end
      // A master that abandons its cycle mid-access gets no ack.
      if (state == ST_ACCESS) cyc_lost <= ~bus.wb_cyc_i;
      if (state == ST_RESP) begin
        if (cur_id == REQ_HK) begin
          bus.hk_valid <= 1'b1;
          bus.hk_rdata <= rd_mux;
        end else if (!cyc_lost && bus.wb_cyc_i) begin
          bus.wb_ack_o <= 1'b1;
          bus.wb_dat_o <= cur_we ? '0 : rd_mux;
        end
      end
    end
  end

endmodule
